// File: rtl/mdu_core.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the MIPS E stage.
// Results are computed at issue, held for a configurable busy time, then committed.
module mdu_core #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       way,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             HIw,
    input  logic             LOw,
    input  logic             md,
    input  logic             mh,
    input  logic             ml,
    output logic             busy,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] rd_data
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t             state_r, state_nxt_s;
    logic [CW-1:0]      cnt_r, cnt_nxt_s;
    logic [WIDTH-1:0]   hi_r, lo_r, hi_d_s, lo_d_s;
    logic [WIDTH-1:0]   hi_nxt_r, lo_nxt_r;
    logic               div0_r;
    logic               load_s, is_mul_s, is_div_s, is_signed_s, valid_s;
    logic [WIDTH-1:0]   res_hi_s, res_lo_s;
    logic [2*WIDTH-1:0] op_a_s, op_b_s, prod_s;
    logic [WIDTH-1:0]   abs_a_s, abs_b_s, div_b_s, uq_s, ur_s;
    logic               neg_a_s, neg_b_s;

    // Operation decode
    always_comb begin
        is_mul_s    = 1'b0;
        is_div_s    = 1'b0;
        is_signed_s = 1'b0;
        case (way)
            3'b001:  begin is_mul_s = 1'b1; is_signed_s = 1'b1; end
            3'b010:  begin is_mul_s = 1'b1; is_signed_s = 1'b0; end
            3'b011:  begin is_div_s = 1'b1; is_signed_s = 1'b1; end
            3'b100:  begin is_div_s = 1'b1; is_signed_s = 1'b0; end
            default: begin is_mul_s = 1'b0; is_div_s = 1'b0; end
        endcase
        valid_s = is_mul_s | is_div_s;
    end

    // Result datapath; signed division works on magnitudes, which also yields INT_MIN/-1 -> INT_MIN, 0
    always_comb begin
        op_a_s  = is_signed_s ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
        op_b_s  = is_signed_s ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
        prod_s  = op_a_s * op_b_s;
        neg_a_s = is_signed_s & a[WIDTH-1];
        neg_b_s = is_signed_s & b[WIDTH-1];
        abs_a_s = neg_a_s ? ({WIDTH{1'b0}} - a) : a;
        abs_b_s = neg_b_s ? ({WIDTH{1'b0}} - b) : b;
        div_b_s = (abs_b_s == {WIDTH{1'b0}}) ? {{(WIDTH-1){1'b0}}, 1'b1} : abs_b_s;
        uq_s    = abs_a_s / div_b_s;
        ur_s    = abs_a_s % div_b_s;
        if (is_mul_s) begin
            res_hi_s = prod_s[2*WIDTH-1:WIDTH];
            res_lo_s = prod_s[WIDTH-1:0];
        end else begin
            res_lo_s = (neg_a_s ^ neg_b_s) ? ({WIDTH{1'b0}} - uq_s) : uq_s;
            res_hi_s = neg_a_s ? ({WIDTH{1'b0}} - ur_s) : ur_s;
        end
    end

    // Next-state, counter and HI/LO update
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        hi_d_s      = hi_r;
        lo_d_s      = lo_r;
        load_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (valid_s) begin
                        load_s      = 1'b1;
                        cnt_nxt_s   = is_mul_s ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                        state_nxt_s = RUN;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else begin
                    if (HIw) hi_d_s = a;
                    else     hi_d_s = hi_r;
                    if (LOw) lo_d_s = a;
                    else     lo_d_s = lo_r;
                end
            end
            RUN: begin
                if (cnt_r <= CW'(1)) begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = {CW{1'b0}};
                    if (!div0_r) begin
                        hi_d_s = hi_nxt_r;
                        lo_d_s = lo_nxt_r;
                    end else begin
                        hi_d_s = hi_r;
                        lo_d_s = lo_r;
                    end
                end else begin
                    cnt_nxt_s = cnt_r - CW'(1);
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = {CW{1'b0}};
            end
        endcase
    end

    // State, counter and register file update with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r  <= IDLE;
            cnt_r    <= {CW{1'b0}};
            hi_r     <= {WIDTH{1'b0}};
            lo_r     <= {WIDTH{1'b0}};
            hi_nxt_r <= {WIDTH{1'b0}};
            lo_nxt_r <= {WIDTH{1'b0}};
            div0_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            hi_r    <= hi_d_s;
            lo_r    <= lo_d_s;
            if (load_s) begin
                hi_nxt_r <= res_hi_s;
                lo_nxt_r <= res_lo_s;
                div0_r   <= is_div_s & (b == {WIDTH{1'b0}});
            end
        end
    end

    assign busy    = (state_r == RUN);
    assign stall   = md & (start | busy);
    assign hi      = hi_r;
    assign lo      = lo_r;
    assign rd_data = mh ? hi_r : (ml ? lo_r : {WIDTH{1'b0}});

endmodule

// File: tb/tb_mdu_core.sv
// Directed self-checking bench for mdu_core: arithmetic results, busy timing,
// HI/LO writes, stall generation and reset abort.
module tb_mdu_core;

    logic        clk = 1'b0;
    logic        reset, start, HIw, LOw, md, mh, ml;
    logic [2:0]  way;
    logic [31:0] a, b;
    logic        busy, stall;
    logic [31:0] hi, lo, rd_data;
    int checks = 0;
    int errors = 0;

    mdu_core #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .way(way), .a(a), .b(b),
        .HIw(HIw), .LOw(LOw), .md(md), .mh(mh), .ml(ml),
        .busy(busy), .stall(stall), .hi(hi), .lo(lo), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    // Issue one operation and count busy cycles (bounded); no checking here.
    task automatic do_op(input logic [2:0] op, input logic [31:0] va, input logic [31:0] vb,
                         output int nbusy, output logic stall_iss);
        @(negedge clk);
        start = 1'b1; way = op; a = va; b = vb; md = 1'b1;
        #1 stall_iss = stall;
        @(negedge clk);
        start = 1'b0; md = 1'b0; way = 3'b000;
        nbusy = 0;
        while (busy && nbusy < 50) begin
            nbusy++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset = 1'b0; start = 1'b0; way = 3'b000; a = 32'h0; b = 32'h0;
        HIw = 1'b0; LOw = 1'b0; md = 1'b0; mh = 1'b0; ml = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h exp 0", hi); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %h exp 0", lo); end
        mh = 1'b1; #1;
        checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL reset_rd got %h exp 0", rd_data); end
        mh = 1'b0; md = 1'b1; start = 1'b1; #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL reset_stall got %b exp 1", stall); end
        md = 1'b0; start = 1'b0;
        @(negedge clk); reset = 1'b1;
    endtask

    task automatic test_mult;
        int n; logic s;
        do_op(3'b001, 32'hFFFFFFFE, 32'd3, n, s);
        checks++; if (s !== 1'b1) begin errors++; $display("FAIL mult_issue_stall got %b exp 1", s); end
        checks++; if (n != 5) begin errors++; $display("FAIL mult_busy got %0d exp 5", n); end
        checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi got %h exp ffffffff", hi); end
        checks++; if (lo !== 32'hFFFFFFFA) begin errors++; $display("FAIL mult_lo got %h exp fffffffa", lo); end
    endtask

    task automatic test_multu;
        int n; logic s;
        do_op(3'b010, 32'hFFFFFFFF, 32'd2, n, s);
        checks++; if (n != 5) begin errors++; $display("FAIL multu_busy got %0d exp 5", n); end
        checks++; if (hi !== 32'h00000001) begin errors++; $display("FAIL multu_hi got %h exp 00000001", hi); end
        checks++; if (lo !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_lo got %h exp fffffffe", lo); end
    endtask

    task automatic test_div;
        int n; logic s;
        do_op(3'b011, 32'hFFFFFFF9, 32'd2, n, s);
        checks++; if (n != 10) begin errors++; $display("FAIL div_busy got %0d exp 10", n); end
        checks++; if (lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_lo got %h exp fffffffd", lo); end
        checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_hi got %h exp ffffffff", hi); end
        do_op(3'b100, 32'd100, 32'd7, n, s);
        checks++; if (lo !== 32'd14) begin errors++; $display("FAIL divu_lo got %h exp 0000000e", lo); end
        checks++; if (hi !== 32'd2) begin errors++; $display("FAIL divu_hi got %h exp 00000002", hi); end
        do_op(3'b011, 32'h80000000, 32'hFFFFFFFF, n, s);
        checks++; if (lo !== 32'h80000000) begin errors++; $display("FAIL ovf_lo got %h exp 80000000", lo); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL ovf_hi got %h exp 0", hi); end
    endtask

    task automatic test_div_zero;
        int n; logic s;
        @(negedge clk); HIw = 1'b1; a = 32'h1234;
        @(negedge clk); HIw = 1'b0; LOw = 1'b1; a = 32'h5678;
        @(negedge clk); LOw = 1'b0; mh = 1'b1; #1;
        checks++; if (rd_data !== 32'h1234) begin errors++; $display("FAIL mthi_rd got %h exp 00001234", rd_data); end
        mh = 1'b0; ml = 1'b1; #1;
        checks++; if (rd_data !== 32'h5678) begin errors++; $display("FAIL mtlo_rd got %h exp 00005678", rd_data); end
        ml = 1'b0;
        do_op(3'b011, 32'd99, 32'd0, n, s);
        checks++; if (n != 10) begin errors++; $display("FAIL div0_busy got %0d exp 10", n); end
        checks++; if (hi !== 32'h1234) begin errors++; $display("FAIL div0_hi got %h exp 00001234", hi); end
        checks++; if (lo !== 32'h5678) begin errors++; $display("FAIL div0_lo got %h exp 00005678", lo); end
    endtask

    task automatic test_mflo_stall;
        int n;
        @(negedge clk); start = 1'b1; way = 3'b001; a = 32'd6; b = 32'd7; md = 1'b1;
        @(negedge clk); start = 1'b0; md = 1'b0;
        @(negedge clk);
        @(negedge clk); md = 1'b1; ml = 1'b1; #1;
        n = 0;
        while (stall && n < 50) begin
            n++;
            @(negedge clk); #1;
        end
        checks++; if (n != 3) begin errors++; $display("FAIL mflo_stall_len got %0d exp 3", n); end
        checks++; if (rd_data !== 32'd42) begin errors++; $display("FAIL mflo_rd got %h exp 0000002a", rd_data); end
        md = 1'b0; ml = 1'b0;
    endtask

    task automatic test_mthi_run;
        @(negedge clk); start = 1'b1; way = 3'b001; a = 32'd2; b = 32'd3; md = 1'b1;
        @(negedge clk); start = 1'b0; md = 1'b0;
        @(negedge clk); HIw = 1'b1; LOw = 1'b1; a = 32'hDEAD;
        @(negedge clk); HIw = 1'b0; LOw = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mthi_run_busy got %b exp 0", busy); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL mthi_run_hi got %h exp 0", hi); end
        checks++; if (lo !== 32'd6) begin errors++; $display("FAIL mthi_run_lo got %h exp 00000006", lo); end
    endtask

    task automatic test_start_wins;
        int n; logic s;
        @(negedge clk); start = 1'b1; way = 3'b111; a = 32'hAAAA; HIw = 1'b1;
        @(negedge clk); start = 1'b0; HIw = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL badway_busy got %b exp 0", busy); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL badway_hi got %h exp 0", hi); end
        HIw = 1'b1;
        do_op(3'b010, 32'd3, 32'd5, n, s);
        HIw = 1'b0;
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL startwins_hi got %h exp 0", hi); end
        checks++; if (lo !== 32'd15) begin errors++; $display("FAIL startwins_lo got %h exp 0000000f", lo); end
    endtask

    task automatic test_reset_run;
        @(negedge clk); start = 1'b1; way = 3'b100; a = 32'd100; b = 32'd7; md = 1'b1;
        @(negedge clk); start = 1'b0; md = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_run_busy_pre got %b exp 1", busy); end
        reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_run_busy got %b exp 0", busy); end
        checks++; if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL rst_run_hilo got %h/%h exp 0/0", hi, lo); end
        repeat (12) @(negedge clk);
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL rst_run_discard got %h exp 0", lo); end
    endtask

    task automatic test_back_to_back;
        int n; logic s;
        do_op(3'b001, 32'd4, 32'd5, n, s);
        do_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, n, s);
        checks++; if (n != 5) begin errors++; $display("FAIL b2b_busy got %0d exp 5", n); end
        checks++; if (hi !== 32'h0 || lo !== 32'd1) begin errors++; $display("FAIL b2b_hilo got %h/%h exp 0/1", hi, lo); end
    endtask

    initial begin
        test_reset;
        test_mult;
        test_multu;
        test_div;
        test_div_zero;
        test_mflo_stall;
        test_mthi_run;
        test_start_wins;
        test_reset_run;
        test_back_to_back;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
